// File: rtl/lcd_nibble_tx_unit.sv
// Sends one LCD byte in 4-bit mode: upper nibble, gap, lower nibble, then the execution wait.
// Bus outputs are zero whenever idle so they can be ORed with the init-phase drivers.
module lcd_nibble_tx_unit #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 50,
  parameter int EXEC_CYC  = 2000,
  parameter int CNT_W     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trans_act,
  input  logic [7:0] tx_data,
  input  logic       tx_rs,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       busy,
  output logic       trans_end
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HI_SETUP  = 4'd1,
    HI_PULSE  = 4'd2,
    HI_HOLD   = 4'd3,
    GAP       = 4'd4,
    LO_SETUP  = 4'd5,
    LO_PULSE  = 4'd6,
    LO_HOLD   = 4'd7,
    EXEC_WAIT = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t           state, state_next, phase_next;
  logic [CNT_W-1:0] cnt, cnt_next, phase_last;
  logic             timed;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             accept;

  assign accept = (state == IDLE) && trans_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        data_q <= tx_data;
        rs_q   <= tx_rs;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    phase_next = IDLE;
    phase_last = '0;
    timed      = 1'b0;
    case (state)
      IDLE: begin
        if (trans_act) begin
          state_next = HI_SETUP;
          cnt_next   = '0;
        end
      end
      HI_SETUP:  begin timed = 1'b1; phase_last = CNT_W'(SETUP_CYC - 1); phase_next = HI_PULSE;  end
      HI_PULSE:  begin timed = 1'b1; phase_last = CNT_W'(PULSE_CYC - 1); phase_next = HI_HOLD;   end
      HI_HOLD:   begin timed = 1'b1; phase_last = CNT_W'(HOLD_CYC - 1);  phase_next = GAP;       end
      GAP:       begin timed = 1'b1; phase_last = CNT_W'(GAP_CYC - 1);   phase_next = LO_SETUP;  end
      LO_SETUP:  begin timed = 1'b1; phase_last = CNT_W'(SETUP_CYC - 1); phase_next = LO_PULSE;  end
      LO_PULSE:  begin timed = 1'b1; phase_last = CNT_W'(PULSE_CYC - 1); phase_next = LO_HOLD;   end
      LO_HOLD:   begin timed = 1'b1; phase_last = CNT_W'(HOLD_CYC - 1);  phase_next = EXEC_WAIT; end
      EXEC_WAIT: begin timed = 1'b1; phase_last = CNT_W'(EXEC_CYC - 1);  phase_next = DONE;      end
      DONE:      state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (timed) begin
      if (cnt == phase_last) begin
        cnt_next   = '0;
        state_next = phase_next;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // Moore output decode; unused encodings fall through to all-zero outputs.
  always_comb begin
    SF_D      = 4'h0;
    LCD_E     = 1'b0;
    LCD_RS    = 1'b0;
    busy      = 1'b0;
    trans_end = 1'b0;
    case (state)
      HI_SETUP, HI_HOLD: begin SF_D = data_q[7:4]; LCD_RS = rs_q; busy = 1'b1; end
      HI_PULSE:          begin SF_D = data_q[7:4]; LCD_E = 1'b1; LCD_RS = rs_q; busy = 1'b1; end
      LO_SETUP, LO_HOLD: begin SF_D = data_q[3:0]; LCD_RS = rs_q; busy = 1'b1; end
      LO_PULSE:          begin SF_D = data_q[3:0]; LCD_E = 1'b1; LCD_RS = rs_q; busy = 1'b1; end
      GAP, EXEC_WAIT:    begin LCD_RS = rs_q; busy = 1'b1; end
      DONE:              begin LCD_RS = rs_q; busy = 1'b1; trans_end = 1'b1; end
      default: ;
    endcase
  end

  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_tx_unit.sv
// Directed bench for lcd_nibble_tx_unit: per-cycle waveform capture of whole transfers
// compared against the documented phase timing.
module tb_lcd_nibble_tx_unit;

  localparam int XFER = 2081;   // trans_end cycle after the accept edge
  localparam int WIN  = 2082;   // capture window includes the IDLE cycle after DONE

  logic       clk = 1'b0;
  logic       reset;
  logic       trans_act;
  logic [7:0] tx_data;
  logic       tx_rs;
  logic [3:0] SF_D;
  logic       LCD_E, LCD_RS, LCD_RW, busy, trans_end;

  int checks = 0;
  int errors = 0;

  logic [3:0] cap_sfd  [0:2099];
  logic       cap_e    [0:2099];
  logic       cap_rs   [0:2099];
  logic       cap_rw   [0:2099];
  logic       cap_te   [0:2099];
  logic       cap_busy [0:2099];

  lcd_nibble_tx_unit dut (
    .clk       (clk),
    .reset     (reset),
    .trans_act (trans_act),
    .tx_data   (tx_data),
    .tx_rs     (tx_rs),
    .SF_D      (SF_D),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .busy      (busy),
    .trans_end (trans_end)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records cycles 1..WIN; called at the sample point of cycle 1.
  task automatic capture(input int mid_k, input logic [7:0] mid_data,
                         input logic end_act, input logic [7:0] end_data);
    for (int k = 1; k <= WIN; k++) begin
      cap_sfd[k]  = SF_D;
      cap_e[k]    = LCD_E;
      cap_rs[k]   = LCD_RS;
      cap_rw[k]   = LCD_RW;
      cap_te[k]   = trans_end;
      cap_busy[k] = busy;
      if (k == mid_k) begin
        trans_act = 1'b0;
        tx_data   = mid_data;
        tx_rs     = ~tx_rs;
      end
      if (k == XFER) begin
        trans_act = end_act;
        tx_data   = end_data;
      end
      step();
    end
  endtask

  task automatic verify(input string name, input logic [7:0] d, input logic rs,
                        output int te_pulses);
    int bad_sfd = 0, bad_e = 0, bad_rs = 0, bad_rw = 0, bad_te = 0, bad_busy = 0;
    int first_sfd = 0, first_e = 0, first_rs = 0, first_te = 0, first_busy = 0;
    logic [3:0] x_sfd;
    logic x_e, x_rs, x_te, x_busy;
    te_pulses = 0;
    for (int k = 1; k <= WIN; k++) begin
      x_sfd  = (k >= 1 && k <= 15) ? d[7:4] : (k >= 66 && k <= 80) ? d[3:0] : 4'h0;
      x_e    = (k >= 3 && k <= 14) || (k >= 68 && k <= 79);
      x_busy = (k <= XFER);
      x_rs   = x_busy ? rs : 1'b0;
      x_te   = (k == XFER);
      if (cap_te[k] === 1'b1) te_pulses++;
      if (cap_sfd[k] !== x_sfd)   begin if (bad_sfd == 0) first_sfd = k;   bad_sfd++;  end
      if (cap_e[k] !== x_e)       begin if (bad_e == 0) first_e = k;       bad_e++;    end
      if (cap_rs[k] !== x_rs)     begin if (bad_rs == 0) first_rs = k;     bad_rs++;   end
      if (cap_rw[k] !== 1'b0)     bad_rw++;
      if (cap_te[k] !== x_te)     begin if (bad_te == 0) first_te = k;     bad_te++;   end
      if (cap_busy[k] !== x_busy) begin if (bad_busy == 0) first_busy = k; bad_busy++; end
    end
    checks++; if (bad_sfd !== 0) begin errors++;
      $display("FAIL %s SF_D: %0d bad cycles, first cycle %0d got %h expected nibble timing for %h", name, bad_sfd, first_sfd, cap_sfd[first_sfd], d); end
    checks++; if (bad_e !== 0) begin errors++;
      $display("FAIL %s LCD_E: %0d bad cycles, first cycle %0d got %b", name, bad_e, first_e, cap_e[first_e]); end
    checks++; if (bad_rs !== 0) begin errors++;
      $display("FAIL %s LCD_RS: %0d bad cycles, first cycle %0d got %b expected rs=%b during 1..2081", name, bad_rs, first_rs, cap_rs[first_rs], rs); end
    checks++; if (bad_rw !== 0) begin errors++;
      $display("FAIL %s LCD_RW: %0d cycles not 0", name, bad_rw); end
    checks++; if (bad_te !== 0) begin errors++;
      $display("FAIL %s trans_end: %0d bad cycles, first cycle %0d got %b expected high only at 2081", name, bad_te, first_te, cap_te[first_te]); end
    checks++; if (bad_busy !== 0) begin errors++;
      $display("FAIL %s busy: %0d bad cycles, first cycle %0d got %b", name, bad_busy, first_busy, cap_busy[first_busy]); end
  endtask

  task automatic start(input logic [7:0] d, input logic rs);
    tx_data   = d;
    tx_rs     = rs;
    trans_act = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int n;
    reset     = 1'b0;
    trans_act = 1'b1;
    tx_data   = 8'h28;
    tx_rs     = 1'b1;
    repeat (3) step();
    checks++; if (SF_D !== 4'h0)      begin errors++; $display("FAIL reset SF_D got %h expected 0", SF_D); end
    checks++; if (LCD_E !== 1'b0)     begin errors++; $display("FAIL reset LCD_E got %b expected 0", LCD_E); end
    checks++; if (LCD_RS !== 1'b0)    begin errors++; $display("FAIL reset LCD_RS got %b expected 0", LCD_RS); end
    checks++; if (LCD_RW !== 1'b0)    begin errors++; $display("FAIL reset LCD_RW got %b expected 0", LCD_RW); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b expected 0", busy); end
    checks++; if (trans_end !== 1'b0) begin errors++; $display("FAIL reset trans_end got %b expected 0", trans_end); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_accept busy got %b expected 1", busy); end
    checks++; if (SF_D !== 4'h2) begin errors++; $display("FAIL reset_accept SF_D got %h expected 2", SF_D); end
    trans_act = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2200) begin step(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_drain busy got %b expected 0 within 2200 cycles", busy); end
  endtask

  task automatic test_single_command();
    int p;
    start(8'h28, 1'b0);
    capture(0, 8'h00, 1'b0, 8'h00);
    verify("cmd_28", 8'h28, 1'b0, p);
  endtask

  task automatic test_data_write();
    int p;
    start(8'h41, 1'b1);
    capture(0, 8'h00, 1'b0, 8'h00);
    verify("data_41", 8'h41, 1'b1, p);
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    start(8'h0C, 1'b0);
    capture(0, 8'h00, 1'b1, 8'h06);
    verify("b2b_first", 8'h0C, 1'b0, p1);
    // Cycle 2083 after the first accept is cycle 1 of the second transfer.
    capture(0, 8'h00, 1'b0, 8'h00);
    verify("b2b_second", 8'h06, 1'b0, p2);
    checks++; if (p1 + p2 !== 2) begin errors++; $display("FAIL b2b pulse_count got %0d expected 2", p1 + p2); end
  endtask

  task automatic test_mid_transfer_change();
    int p;
    start(8'h5A, 1'b1);
    capture(30, 8'hFF, 1'b0, 8'h00);
    verify("mid_change", 8'h5A, 1'b1, p);
  endtask

  task automatic test_reset_abort();
    int p;
    int te_seen = 0;
    start(8'hA5, 1'b1);
    trans_act = 1'b0;
    repeat (69) step();  // now at cycle 70, inside LO_PULSE
    checks++; if (LCD_E !== 1'b1 || SF_D !== 4'h5) begin errors++;
      $display("FAIL abort_pre LCD_E/SF_D got %b/%h expected 1/5", LCD_E, SF_D); end
    #2 reset = 1'b0;
    #1;
    checks++; if (LCD_E !== 1'b0 || SF_D !== 4'h0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_async LCD_E/SF_D/busy got %b/%h/%b expected 0/0/0", LCD_E, SF_D, busy); end
    for (int k = 0; k < 5; k++) begin
      step();
      if (trans_end === 1'b1) te_seen++;
    end
    checks++; if (te_seen !== 0) begin errors++; $display("FAIL abort_no_trans_end got %0d pulses expected 0", te_seen); end
    tx_data   = 8'h3C;
    tx_rs     = 1'b0;
    trans_act = 1'b1;
    reset     = 1'b1;
    step();
    trans_act = 1'b0;
    capture(0, 8'h00, 1'b0, 8'h00);
    verify("after_abort", 8'h3C, 1'b0, p);
  endtask

  initial begin
    reset     = 1'b0;
    trans_act = 1'b0;
    tx_data   = 8'h00;
    tx_rs     = 1'b0;
    #1;
    test_reset();
    test_single_command();
    test_data_write();
    test_back_to_back();
    test_mid_transfer_change();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
